// File: rtl/dm_responder_if.sv
// Load/store handshake between the core datapath and the data-memory responder.
// The core drives strobes, address and store data; the responder returns completion.
interface dm_responder_if;
   logic        do_dm_read;
   logic        do_dm_write;
   logic [31:0] dm_address;
   logic [31:0] dm_in;
   logic [31:0] dm_out;
   logic        dm_ready;
   logic        dm_error;
   logic        dm_busy;

   modport master (
      output do_dm_read, do_dm_write, dm_address, dm_in,
      input  dm_out, dm_ready, dm_error, dm_busy
   );

   modport slave (
      input  do_dm_read, do_dm_write, dm_address, dm_in,
      output dm_out, dm_ready, dm_error, dm_busy
   );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one word load/store at a time, fixed wait states,
// then a one-cycle registered completion pulse with load data or error.
module dm_responder #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clock,
   input  logic          reset,
   dm_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t                  state, state_n;
   logic [3:0]              cnt, cnt_n;
   logic                    accept;
   logic                    enter;

   logic                    wr_q, err_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [31:0]             data_q;

   logic                    req, in_err;
   logic [ADDR_WIDTH-1:0]   in_idx;

   logic                    cur_wr, cur_err;
   logic [ADDR_WIDTH-1:0]   cur_idx;
   logic [31:0]             cur_data;
   logic                    commit_wr, commit_rd;

   logic [31:0]             out_q;
   logic                    ready_q, error_q, busy_q;

   logic [31:0]             mem [DEPTH];

   assign req    = bus.do_dm_read | bus.do_dm_write;
   assign in_idx = bus.dm_address[ADDR_WIDTH+1:2];
   assign in_err = (bus.do_dm_read & bus.do_dm_write)
                 | (bus.dm_address[1:0] != 2'b00)
                 | (|bus.dm_address[31:ADDR_WIDTH+2]);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_n   = WAIT_LOAD;
               state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // With zero wait states the commit happens on the accept edge,
   // so the live request is used instead of the latched copy.
   assign enter     = (state_n == RESP) && (state != RESP);
   assign cur_wr    = accept ? bus.do_dm_write : wr_q;
   assign cur_err   = accept ? in_err          : err_q;
   assign cur_idx   = accept ? in_idx          : idx_q;
   assign cur_data  = accept ? bus.dm_in       : data_q;
   assign commit_wr = enter &  cur_wr & ~cur_err;
   assign commit_rd = enter & ~cur_wr & ~cur_err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         data_q  <= 32'd0;
         out_q   <= 32'd0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ready_q <= enter;
         error_q <= enter & cur_err;
         busy_q  <= (state_n != IDLE);
         if (accept) begin
            wr_q   <= bus.do_dm_write;
            err_q  <= in_err;
            idx_q  <= in_idx;
            data_q <= bus.dm_in;
         end
         if (commit_rd)
            out_q <= mem[cur_idx];
         else if (enter && cur_err)
            out_q <= 32'd0;
      end
   end

   // The array has no reset so its contents survive; a held reset blocks commits.
   always_ff @(posedge clock) begin
      if (reset && commit_wr) mem[cur_idx] <= cur_data;
   end

   assign bus.dm_out   = out_q;
   assign bus.dm_ready = ready_q;
   assign bus.dm_error = error_q;
   assign bus.dm_busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: two instances (2 and 0 wait states),
// directed loads/stores with hand-computed results, latency and error checks.
module tb_dm_responder;

   typedef struct {
      int          cyc;
      logic [31:0] out;
      logic        err;
      bit          chk;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t qa[$];
   exp_t qb[$];

   dm_responder_if ifa ();
   dm_responder_if ifb ();

   dm_responder #(
      .DEPTH(1024), .ADDR_WIDTH(10), .WAIT_CYCLES(2)
   ) dut_a (
      .clock(clock), .reset(reset), .bus(ifa)
   );

   dm_responder #(
      .DEPTH(1024), .ADDR_WIDTH(10), .WAIT_CYCLES(0)
   ) dut_b (
      .clock(clock), .reset(reset), .bus(ifb)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (ifa.dm_ready === 1'b1) begin
         chk("a_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) begin
            exp_t e;
            e = qa.pop_front();
            chk("a_latency", cyc, e.cyc);
            chk("a_error", 32'(ifa.dm_error), 32'(e.err));
            if (e.chk) chk("a_out", ifa.dm_out, e.out);
         end
      end
   end

   always @(negedge clock) begin
      if (ifb.dm_ready === 1'b1) begin
         chk("b_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) begin
            exp_t e;
            e = qb.pop_front();
            chk("b_latency", cyc, e.cyc);
            chk("b_error", 32'(ifb.dm_error), 32'(e.err));
            if (e.chk) chk("b_out", ifb.dm_out, e.out);
         end
      end
   end

   task automatic drive(input bit b, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (b) begin
         ifb.do_dm_read  = rd;
         ifb.do_dm_write = wr;
         ifb.dm_address  = a;
         ifb.dm_in       = d;
      end else begin
         ifa.do_dm_read  = rd;
         ifa.do_dm_write = wr;
         ifa.dm_address  = a;
         ifa.dm_in       = d;
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge leaving RESP
   // with the strobes still held, as the core would.
   task automatic req(input bit b, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_out, input logic exp_err,
                      input bit chk_out, input bit chg = 1'b0,
                      input logic [31:0] a2 = 32'd0,
                      input logic [31:0] d2 = 32'd0);
      exp_t e;
      bit   got;
      e.cyc = cyc + (b ? 1 : 3);
      e.out = exp_out;
      e.err = exp_err;
      e.chk = chk_out;
      drive(b, rd, wr, a, d);
      if (b) qb.push_back(e);
      else   qa.push_back(e);
      if (chg) begin
         @(posedge clock);
         #1;
         drive(b, rd, wr, a2, d2);
      end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if ((b ? ifb.dm_ready : ifa.dm_ready) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk(b ? "b_ready_seen" : "a_ready_seen", 32'(got), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 32'd0, 32'd0);
      drive(1, 0, 0, 32'd0, 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_a_ready", 32'(ifa.dm_ready), 32'd0);
      chk("rst_a_error", 32'(ifa.dm_error), 32'd0);
      chk("rst_a_busy",  32'(ifa.dm_busy),  32'd0);
      chk("rst_a_out",   ifa.dm_out,        32'd0);
      chk("rst_b_ready", 32'(ifb.dm_ready), 32'd0);
      chk("rst_b_error", 32'(ifb.dm_error), 32'd0);
      chk("rst_b_busy",  32'(ifb.dm_busy),  32'd0);
      chk("rst_b_out",   ifb.dm_out,        32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clock);
      @(negedge clock);
      chk("idle_a_busy", 32'(ifa.dm_busy), 32'd0);
      chk("idle_a_err",  32'(ifa.dm_error), 32'd0);
      chk("idle_a_out",  ifa.dm_out,       32'd0);
      chk("idle_b_busy", 32'(ifb.dm_busy), 32'd0);
      @(posedge clock);
      #1;

      req(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 32'hDEADBEEF, 0, 1);
      req(0, 1, 0, 32'h12, 32'd0, 32'd0, 1, 1);
      req(0, 0, 1, 32'h0, 32'h55AA55AA, 32'd0, 0, 0);
      req(0, 1, 0, 32'h0, 32'd0, 32'h55AA55AA, 0, 1);
      req(0, 0, 1, 32'h1000, 32'h99, 32'd0, 1, 1);
      req(0, 1, 0, 32'h0, 32'd0, 32'h55AA55AA, 0, 1);
      req(0, 1, 1, 32'h10, 32'h0BADF00D, 32'd0, 1, 1);
      req(0, 1, 0, 32'h10, 32'd0, 32'hDEADBEEF, 0, 1);
      req(0, 0, 1, 32'h20, 32'h0F0F0F0F, 32'd0, 0, 0);

      drive(0, 0, 1, 32'h20, 32'h12345678);
      @(posedge clock);
      #1;
      chk("mid_busy", 32'(ifa.dm_busy), 32'd1);
      reset = 1'b0;
      drive(0, 0, 0, 32'd0, 32'd0);
      #1;
      chk("abort_busy",  32'(ifa.dm_busy),  32'd0);
      chk("abort_ready", 32'(ifa.dm_ready), 32'd0);
      chk("abort_out",   ifa.dm_out,        32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      req(0, 1, 0, 32'h20, 32'd0, 32'h0F0F0F0F, 0, 1);

      req(0, 0, 1, 32'h44, 32'h11111111, 32'd0, 0, 0);
      req(0, 0, 1, 32'h40, 32'hA5A5A5A5, 32'd0, 0, 0,
          1'b1, 32'h44, 32'hFFFFFFFF);
      req(0, 1, 0, 32'h40, 32'd0, 32'hA5A5A5A5, 0, 1);
      req(0, 1, 0, 32'h44, 32'd0, 32'h11111111, 0, 1);
      drive(0, 0, 0, 32'd0, 32'd0);

      req(1, 0, 1, 32'h8, 32'hCAFEF00D, 32'd0, 0, 0);
      req(1, 1, 0, 32'h8, 32'd0, 32'hCAFEF00D, 0, 1);
      req(1, 1, 0, 32'h8, 32'd0, 32'hCAFEF00D, 0, 1);
      req(1, 1, 0, 32'h9, 32'd0, 32'd0, 1, 1);
      req(1, 1, 0, 32'h8, 32'd0, 32'hCAFEF00D, 0, 1);
      drive(1, 0, 0, 32'd0, 32'd0);

      repeat (6) @(posedge clock);
      @(negedge clock);
      chk("a_drained", 32'(qa.size()), 32'd0);
      chk("b_drained", 32'(qb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder: the memory-side end of the core's `do_dm_read`/`do_dm_write` strobes. It accepts one word-sized load or store at a time, inserts a programmable number of wait states, and then returns a one-cycle `dm_ready` completion (with read data for loads). It sits between the core datapath and the on-chip data RAM array, and gives the pipeline a deterministic stall point for slow memory.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array (power of two).
- `ADDR_WIDTH`, 10: log2(`DEPTH`); width of the word index.
- `WAIT_CYCLES`, 2: wait states between accept and completion (0–15).
- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `do_dm_read` input 1: load request strobe; held by the core until `dm_ready`.
- `do_dm_write` input 1: store request strobe; held by the core until `dm_ready`.
- `dm_address` input 32: byte address; valid while a strobe is high.
- `dm_in` input 32: store data; valid with `do_dm_write`.
- `dm_out` output 32: load data; valid while `dm_ready` is high for a load.
- `dm_ready` output 1: one-cycle completion pulse.
- `dm_error` output 1: asserted with `dm_ready` when the request was rejected.
- `dm_busy` output 1: high from the cycle after accept through the `RESP` cycle.

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`. All outputs are registered.
- **Accept.** In `IDLE`, a rising edge with either strobe high accepts the request.
  - Latch the type, word index `dm_address[ADDR_WIDTH+1:2]`, `dm_in` and the error condition.
  - Load the wait counter with `WAIT_CYCLES`.
  - Next state is `WAIT`, or `RESP` directly if `WAIT_CYCLES`=0.
- **Wait.** In `WAIT`, the counter decrements each edge. It leaves for `RESP` on the edge where the counter is 1.
- **Entering `RESP`:**
  - Valid store: `mem[idx] <= data`.
  - Valid load: `dm_out <= mem[idx]`.
  - Error: no array access, and `dm_out <= 0`.
- **`RESP`.** Lasts exactly one cycle with `dm_ready`=1, then returns to `IDLE` unconditionally.
  - Strobes are not sampled during `RESP`, so a strobe still high here is not a new request.
  - The core deasserts or changes its strobes after seeing `dm_ready`.
- **Error conditions**, latched at accept:
  - Both strobes high.
  - `dm_address[1:0]` != 0 (misaligned).
  - `dm_address` >= `DEPTH`*4 (out of range).
  - An error still completes normally (same latency), with `dm_error`=1 for the `RESP` cycle and memory unchanged.
- **`dm_out` between loads.** `dm_out` holds its last value outside `RESP`. Stores and errors do not update it, except that an error clears it to 0.
- **Request changes.** Strobes, address or data that change after accept are ignored until the next `IDLE` accept.
- **Array contents.** The array is not reset; its contents survive `reset`.

## Timing
- Reset values: state `IDLE`, `dm_out`=0, `dm_ready`=0, `dm_error`=0, `dm_busy`=0, counter 0.
- Reset mid-operation aborts immediately. A store not yet committed (state `WAIT`) is discarded, and no `dm_ready` is issued.
- Latency: request first high in cycle N (`IDLE`) → `dm_ready` high in cycle N+`WAIT_CYCLES`+1.
- Throughput: one access per `WAIT_CYCLES`+2 cycles, because at least one `IDLE` cycle separates transactions.
- Read-after-write: a load accepted after a store's `RESP` returns the stored value.
- `dm_busy` is high in `WAIT` and `RESP`, and low in `IDLE`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → all outputs 0. Release, leave strobes idle for 5 cycles → outputs stay 0.
- **Store then load:** `WAIT_CYCLES`=2. Store 0xDEADBEEF to 0x00000010, then load 0x00000010 → each `dm_ready` arrives exactly 3 cycles after its strobe rises. The load returns `dm_out`=0xDEADBEEF with `dm_error`=0.
- **Zero wait:** `WAIT_CYCLES`=0. Back-to-back loads with strobes held until ready → `dm_ready` 1 cycle after each request, and one idle cycle between pulses.
- **Errors:**
  - Load 0x00000012 → `dm_ready`=`dm_error`=1 and `dm_out`=0.
  - Store 0x00001000 (`DEPTH`=1024) → error, and a later read of word 0 is unchanged.
  - Both strobes high → error, and the array is unchanged.
- **Reset mid-operation:** store 0x12345678 to 0x20, assert `reset` while in `WAIT` → no `dm_ready`. A later load of 0x20 returns the pre-store value.
- **Ignored changes:** change `dm_address` and `dm_in` during `WAIT` → the originally latched address and data are used.
